axil_sram_slave: RTL

- AXI-lite slave with a complete read path and write path around an internal word-addressed memory array.
- Generalises the fixed-delay, read-only instruction SRAM model. Adds configurable data/address width, configurable depth and base address, byte-strobe writes and SLVERR on out-of-range addresses.
- Latency is a configurable fixed minimum plus an optional pseudo-random extra delay from an LFSR.
- Serves as the memory-side model behind the IFU/LSU AXI-lite masters for latency-tolerance testing.

---
 rtl/axil_sram_slave.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axil_sram_slave.sv
// AXI-lite slave in front of a word-addressed SRAM, with byte strobes, SLVERR on
// out-of-range addresses and a fixed-plus-LFSR-random response latency.
module axil_sram_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                MIN_LAT     = 1,
    parameter int                RAND_LAT    = 1,
    parameter logic [7:0]        LFSR_SEED   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = 16;
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH_WORDS * STRB_W);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_RESP = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [2:0]        state;
    logic [7:0]        lfsr;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              lfsr_fb;
    logic [CNT_W-1:0]  cnt_load;
    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic [IDX_W-1:0]  index;
    logic              rd_req;
    logic              wr_req;
    logic              grant_rd;
    logic              grant_wr;
    logic              wait_done;

    // Taps x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign cnt_load = CNT_W'(MIN_LAT - 1) + ((RAND_LAT != 0) ? CNT_W'(lfsr[2:0]) : '0);

    // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range.
    assign offset    = addr_q - BASE_ADDR;
    assign in_range  = {1'b0, offset} < SPAN;
    assign index     = offset[OFF_W +: IDX_W];
    assign wait_done = (cnt == '0);

    assign rd_req   = arvalid;
    assign wr_req   = awvalid && wvalid;
    assign grant_rd = rd_req && (!wr_req || (last_grant == GRANT_WRITE));
    assign grant_wr = wr_req && (!rd_req || (last_grant == GRANT_READ));

    assign arready = (state == IDLE) && grant_rd;
    assign awready = (state == IDLE) && grant_wr;
    assign wready  = (state == IDLE) && grant_wr;
    assign rvalid  = (state == RD_RESP);
    assign bvalid  = (state == WR_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            last_grant <= GRANT_WRITE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            bresp      <= RESP_OKAY;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        addr_q     <= araddr;
                        cnt        <= cnt_load;
                        last_grant <= GRANT_READ;
                        state      <= RD_WAIT;
                    end else if (grant_wr) begin
                        addr_q     <= awaddr;
                        wdata_q    <= wdata;
                        wstrb_q    <= wstrb;
                        cnt        <= cnt_load;
                        last_grant <= GRANT_WRITE;
                        state      <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        rdata <= in_range ? mem[index] : '0;
                        rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
                        state <= RD_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rdata <= '0;
                        rresp <= RESP_OKAY;
                        state <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wait_done) begin
                        bresp <= in_range ? RESP_OKAY : RESP_SLVERR;
                        state <= WR_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bresp <= RESP_OKAY;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The memory is never reset; an async reset forces state to IDLE, which blocks the commit.
    always_ff @(posedge clk) begin
        if ((state == WR_WAIT) && wait_done && in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[index][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
